// File: rtl/alu_seq_unit.sv
// Sequential ALU: single-cycle logic/arith, bit-serial SRL/SLL, held result.
// Define ALU_SEQ_OVERFLOW_EN to register signed overflow for ADD/SUB.
module alu_seq_unit #(
   parameter int DATA_WIDTH  = 32,
   parameter int SHAMT_WIDTH = 5
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   valid_i,
   output logic                   ready_o,
   input  logic [3:0]             alu_operation_i,
   input  logic [DATA_WIDTH-1:0]  a_i,
   input  logic [DATA_WIDTH-1:0]  b_i,
   input  logic [SHAMT_WIDTH-1:0] shamt_i,
   output logic                   valid_o,
   input  logic                   ready_i,
   output logic [DATA_WIDTH-1:0]  result_o,
   output logic                   zero_o,
   output logic                   illegal_o,
   output logic                   overflow_o
);

   localparam int HALF = DATA_WIDTH / 2;
   localparam logic [SHAMT_WIDTH-1:0] CNT_ONE = SHAMT_WIDTH'(1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      RESP
   } state_t;

   state_t state, next_state;

   logic [DATA_WIDTH-1:0]  acc_q;
   logic [SHAMT_WIDTH-1:0] cnt_q;
   logic                   left_q;
   logic                   zero_q;
   logic                   illegal_q;

   logic op_add, op_sub, op_or, op_srl;
   logic op_sll, op_lui, op_and, op_nor;

   logic [DATA_WIDTH-1:0] sum, diff;
   logic [DATA_WIDTH-1:0] alu_res;
   logic [DATA_WIDTH-1:0] shift_nxt;
   logic                  alu_illegal;
   logic                  accept;
   logic                  is_shift;
   logic                  shift_last;

   always_comb begin
      op_add = 1'b0;
      op_sub = 1'b0;
      op_or  = 1'b0;
      op_srl = 1'b0;
      op_sll = 1'b0;
      op_lui = 1'b0;
      op_and = 1'b0;
      op_nor = 1'b0;
      case (alu_operation_i)
         4'b0000, 4'b1000, 4'b1001: op_add = 1'b1;
         4'b0001:                   op_sub = 1'b1;
         4'b0010, 4'b0011:          op_or  = 1'b1;
         4'b0100:                   op_srl = 1'b1;
         4'b0101:                   op_sll = 1'b1;
         4'b0110:                   op_lui = 1'b1;
         4'b0111, 4'b1101:          op_and = 1'b1;
         4'b1100:                   op_nor = 1'b1;
         default: ;
      endcase
   end

   assign sum  = a_i + b_i;
   assign diff = a_i - b_i;

   always_comb begin
      alu_res     = '0;
      alu_illegal = 1'b0;
      unique case (1'b1)
         op_add: alu_res = sum;
         op_sub: alu_res = diff;
         op_or:  alu_res = a_i | b_i;
         op_srl: alu_res = b_i >> shamt_i;
         op_sll: alu_res = b_i << shamt_i;
         op_lui: alu_res = {b_i[HALF-1:0], {HALF{1'b0}}};
         op_and: alu_res = a_i & b_i;
         op_nor: alu_res = ~(a_i | b_i);
         default: alu_illegal = 1'b1;
      endcase
   end

   assign accept     = valid_i && (state == IDLE);
   assign is_shift   = (op_srl || op_sll) && (shamt_i != '0);
   assign shift_last = (cnt_q == CNT_ONE);
   assign shift_nxt  = left_q ? (acc_q << 1) : (acc_q >> 1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      ready_o    = 1'b0;
      valid_o    = 1'b0;
      unique case (state)
         IDLE: begin
            ready_o = 1'b1;
            if (valid_i) begin
               next_state = is_shift ? SHIFT : RESP;
            end
         end
         SHIFT: begin
            if (shift_last) begin
               next_state = RESP;
            end
         end
         RESP: begin
            valid_o = 1'b1;
            if (ready_i) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // acc_q doubles as shift accumulator and held result
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_q     <= '0;
         cnt_q     <= '0;
         left_q    <= 1'b0;
         zero_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else if (accept) begin
         left_q <= op_sll;
         if (is_shift) begin
            acc_q     <= b_i;
            cnt_q     <= shamt_i;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
         end else begin
            acc_q     <= alu_res;
            zero_q    <= (alu_res == '0);
            illegal_q <= alu_illegal;
         end
      end else if (state == SHIFT) begin
         acc_q <= shift_nxt;
         cnt_q <= cnt_q - CNT_ONE;
         if (shift_last) begin
            zero_q <= (shift_nxt == '0);
         end
      end
   end

   assign result_o  = acc_q;
   assign zero_o    = zero_q;
   assign illegal_o = illegal_q;

`ifdef ALU_SEQ_OVERFLOW_EN
   logic ovf_q;
   logic ovf_c;

   // address adds (1000/1001) never flag overflow
   always_comb begin
      ovf_c = 1'b0;
      if (alu_operation_i == 4'b0000) begin
         ovf_c = (a_i[DATA_WIDTH-1] == b_i[DATA_WIDTH-1]) &&
                 (sum[DATA_WIDTH-1] != a_i[DATA_WIDTH-1]);
      end else if (alu_operation_i == 4'b0001) begin
         ovf_c = (a_i[DATA_WIDTH-1] != b_i[DATA_WIDTH-1]) &&
                 (diff[DATA_WIDTH-1] != a_i[DATA_WIDTH-1]);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ovf_q <= 1'b0;
      end else if (accept) begin
         ovf_q <= ovf_c;
      end
   end

   assign overflow_o = ovf_q;
`else
   assign overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed-vector bench for alu_seq_unit.
// Expected values are hand-computed constants.
module tb_alu_seq_unit;

   logic        clk;
   logic        reset;
   logic        valid_i;
   logic        ready_o;
   logic [3:0]  alu_operation_i;
   logic [31:0] a_i;
   logic [31:0] b_i;
   logic [4:0]  shamt_i;
   logic        valid_o;
   logic        ready_i;
   logic [31:0] result_o;
   logic        zero_o;
   logic        illegal_o;
   logic        overflow_o;

   int n_checks;
   int n_errors;

`ifdef ALU_SEQ_OVERFLOW_EN
   localparam logic OVF = 1'b1;
`else
   localparam logic OVF = 1'b0;
`endif

   alu_seq_unit #(
      .DATA_WIDTH (32),
      .SHAMT_WIDTH(5)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .valid_i        (valid_i),
      .ready_o        (ready_o),
      .alu_operation_i(alu_operation_i),
      .a_i            (a_i),
      .b_i            (b_i),
      .shamt_i        (shamt_i),
      .valid_o        (valid_o),
      .ready_i        (ready_i),
      .result_o       (result_o),
      .zero_o         (zero_o),
      .illegal_o      (illegal_o),
      .overflow_o     (overflow_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called one step after an edge with the DUT idle; ready_i held high.
   task automatic run_op(input string tag,
                         input logic [3:0] op,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [4:0] sh,
                         input int lat,
                         input logic [31:0] res,
                         input logic z,
                         input logic il,
                         input logic ov);
      int n;
      valid_i = 1'b1;
      alu_operation_i = op;
      a_i = a;
      b_i = b;
      shamt_i = sh;
      ready_i = 1'b1;
      tick();
      n = 1;
      valid_i = 1'b0;
      a_i = 32'hDEADBEEF;
      b_i = 32'h5A5A5A5A;
      shamt_i = 5'd7;
      while (!valid_o && n < 40) begin
         tick();
         n++;
      end
      check({tag, "_lat"}, n, lat);
      check({tag, "_res"}, result_o, res);
      check({tag, "_zero"}, {31'd0, zero_o}, {31'd0, z});
      check({tag, "_ill"}, {31'd0, illegal_o}, {31'd0, il});
      check({tag, "_ovf"}, {31'd0, overflow_o}, {31'd0, ov});
      check({tag, "_rdy_busy"}, {31'd0, ready_o}, 32'd0);
      tick();
      check({tag, "_vld_drop"}, {31'd0, valid_o}, 32'd0);
      check({tag, "_rdy_back"}, {31'd0, ready_o}, 32'd1);
   endtask

   initial begin
      int n;
      n_checks = 0;
      n_errors = 0;
      reset = 1'b0;
      valid_i = 1'b0;
      ready_i = 1'b0;
      alu_operation_i = 4'b0000;
      a_i = '0;
      b_i = '0;
      shamt_i = '0;
      tick();
      tick();
      check("rst_ready", {31'd0, ready_o}, 32'd1);
      check("rst_valid", {31'd0, valid_o}, 32'd0);
      check("rst_result", result_o, 32'd0);
      check("rst_zero", {31'd0, zero_o}, 32'd0);
      check("rst_ill", {31'd0, illegal_o}, 32'd0);
      check("rst_ovf", {31'd0, overflow_o}, 32'd0);
      reset = 1'b1;
      tick();

      // Reset mid-SHIFT: SLL shamt 20, reset in 5th shift cycle
      valid_i = 1'b1;
      alu_operation_i = 4'b0101;
      b_i = 32'h1;
      shamt_i = 5'd20;
      ready_i = 1'b1;
      tick();
      valid_i = 1'b0;
      repeat (4) tick();
      check("mid_busy", {31'd0, ready_o}, 32'd0);
      reset = 1'b0;
      #1;
      check("mid_rst_ready", {31'd0, ready_o}, 32'd1);
      check("mid_rst_valid", {31'd0, valid_o}, 32'd0);
      check("mid_rst_result", result_o, 32'd0);
      tick();
      reset = 1'b1;
      tick();
      run_op("sll3", 4'b0101, 32'h0, 32'h1, 5'd3, 4, 32'h8, 0, 0, 0);

      run_op("add_ovf", 4'b0000, 32'h7FFFFFFF, 32'h1, 5'd0, 1,
             32'h80000000, 0, 0, OVF);
      run_op("sub_zero", 4'b0001, 32'd5, 32'd5, 5'd0, 1,
             32'h0, 1, 0, 0);
      run_op("sub_ovf", 4'b0001, 32'h80000000, 32'h1, 5'd0, 1,
             32'h7FFFFFFF, 0, 0, OVF);
      run_op("addi_noovf", 4'b1000, 32'h7FFFFFFF, 32'h1, 5'd0, 1,
             32'h80000000, 0, 0, 0);
      run_op("sw_add", 4'b1001, 32'h100, 32'h24, 5'd0, 1,
             32'h124, 0, 0, 0);
      run_op("nor", 4'b1100, 32'h0, 32'h0, 5'd0, 1,
             32'hFFFFFFFF, 0, 0, 0);
      run_op("or", 4'b0011, 32'hF0, 32'h0F, 5'd0, 1,
             32'hFF, 0, 0, 0);
      run_op("and", 4'b1101, 32'hFF00, 32'h0FF0, 5'd0, 1,
             32'h0F00, 0, 0, 0);
      run_op("srl31", 4'b0100, 32'h0, 32'h80000000, 5'd31, 32,
             32'h1, 0, 0, 0);
      run_op("srl4", 4'b0100, 32'h0, 32'hF0, 5'd4, 5,
             32'hF, 0, 0, 0);
      run_op("srl_zero", 4'b0100, 32'h0, 32'h8, 5'd4, 5,
             32'h0, 1, 0, 0);
      run_op("sll0", 4'b0101, 32'h0, 32'h1234, 5'd0, 1,
             32'h1234, 0, 0, 0);
      run_op("lui", 4'b0110, 32'h0, 32'h0000ABCD, 5'd0, 1,
             32'hABCD0000, 0, 0, 0);
      run_op("ill", 4'b1111, 32'h3, 32'h4, 5'd0, 1,
             32'h0, 1, 1, 0);
      run_op("ill_1010", 4'b1010, 32'h3, 32'h4, 5'd0, 1,
             32'h0, 1, 1, 0);

      // Back-pressure in RESP with input churn
      valid_i = 1'b1;
      alu_operation_i = 4'b0000;
      a_i = 32'd3;
      b_i = 32'd4;
      shamt_i = 5'd0;
      ready_i = 1'b0;
      tick();
      n = 1;
      while (!valid_o && n < 40) begin
         tick();
         n++;
      end
      check("bp_lat", n, 1);
      for (int i = 0; i < 10; i++) begin
         valid_i = i[0];
         a_i = 32'h1111 * i;
         b_i = ~(32'h2222 * i);
         alu_operation_i = 4'(i);
         tick();
         check("bp_valid", {31'd0, valid_o}, 32'd1);
         check("bp_ready", {31'd0, ready_o}, 32'd0);
         check("bp_res", result_o, 32'd7);
         check("bp_zero", {31'd0, zero_o}, 32'd0);
      end
      valid_i = 1'b0;
      ready_i = 1'b1;
      tick();
      check("bp_vld_drop", {31'd0, valid_o}, 32'd0);
      check("bp_rdy_back", {31'd0, ready_o}, 32'd1);

      run_op("after_bp", 4'b0111, 32'hF0F0, 32'hFF00, 5'd0, 1,
             32'hF000, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/alu_seq_unit.md
# alu_seq_unit

Sequential ALU consuming the 4-bit operation code produced by the ALU control decoder. It accepts one operation at a time over a valid/ready handshake and captures operands. Logical and arithmetic ops complete in one cycle; SRL/SLL iterate one bit per cycle. Each result is held with flags until the downstream consumer accepts it. It sits between the register-file/immediate muxes and the write-back/memory-address path.

## Interface
- DATA_WIDTH, 32: operand/result width; must be even.
- SHAMT_WIDTH, 5: shift-amount width.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- valid_i  in  1  operation request.
- ready_o  out  1  unit can accept; high only in IDLE.
- alu_operation_i  in  4  op code from ALU control decoder.
- a_i  in  DATA_WIDTH  operand A (rs).
- b_i  in  DATA_WIDTH  operand B (rt or immediate).
- shamt_i  in  SHAMT_WIDTH  shift amount.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer accepts result.
- result_o  out  DATA_WIDTH  result.
- zero_o  out  1  result_o == 0.
- illegal_o  out  1  op code not in the supported set.
- overflow_o  out  1  signed overflow (see Configuration).

## Operation
- Op codes:
  - 0000/1000/1001: A+B (ADD, ADDI, LW, SW address).
  - 0001: A-B.
  - 0010/0011: A|B.
  - 0100: B>>shamt, logical.
  - 0101: B<<shamt.
  - 0110: {B[DATA_WIDTH/2-1:0], DATA_WIDTH/2 zeros} (LUI).
  - 0111/1101: A&B.
  - 1100: ~(A|B).
  - 1010, 1011, 1110, 1111: result 0, illegal_o=1.
- Arithmetic is modulo 2^DATA_WIDTH; carry-out is discarded.
- FSM states: IDLE, SHIFT, RESP.
  - IDLE: when valid_i && ready_o, capture op, A, B and shamt. Go to SHIFT if the op is a shift and shamt != 0; otherwise compute and go to RESP.
  - SHIFT: shift the accumulator (initialised from B) one bit per cycle and decrement the counter. When the counter reaches 0, go to RESP.
  - RESP: valid_o=1; result and flags are stable. When ready_i=1, return to IDLE.
- Operand inputs are ignored outside the accept cycle. Changes on a_i/b_i during SHIFT or RESP have no effect.
- valid_i while not in IDLE is ignored. There is no queuing; the requester must hold valid_i until ready_o.
- zero_o and illegal_o are registered with result_o and valid only while valid_o=1.

## Timing
- Reset values: ready_o=1 (state IDLE); valid_o, result_o, zero_o, illegal_o, overflow_o all 0.
- Reset asserted mid-SHIFT or mid-RESP aborts the operation immediately; the pending result is lost.
- Accept in cycle t:
  - Non-shift op, or shift with shamt 0: valid_o rises in cycle t+1.
  - Shift with shamt n>0: SHIFT occupies cycles t+1..t+n; valid_o rises in cycle t+n+1.
- The worst case is shamt 31 (32-cycle latency).
- ready_o is high only in IDLE. The earliest back-to-back accept is the cycle after the RESP handshake.
- valid_o && ready_i in cycle r: valid_o=0 and ready_o=1 in cycle r+1.
- If ready_i is already high when valid_o rises, the handshake completes in that same cycle.
- Outputs hold without change while valid_o=1 && ready_i=0.

## Configuration
- ALU_SEQ_OVERFLOW_EN defined: overflow_o flags signed overflow for op 0000 and 0001, registered with the result. Op codes 1000/1001 (address add) never flag overflow.
- Undefined: overflow_o is tied to 0 and no overflow logic is synthesised. Port list is identical in both builds.

## Test plan
- Reset mid-SHIFT (op 0101, shamt 20, reset low at the 5th SHIFT cycle) -> ready_o=1, valid_o=0, result_o=0 immediately; the next op executes normally.
- ADD A=0x7FFFFFFF, B=1, ready_i=1 -> valid_o at t+1 for one cycle, result 0x80000000, zero_o=0. overflow_o=1 only with ALU_SEQ_OVERFLOW_EN, else 0.
- SUB A=5, B=5 -> result 0, zero_o=1. NOR A=0, B=0 -> 0xFFFFFFFF.
- SRL B=0x80000000, shamt 31 -> valid_o at t+32, result 0x00000001. SLL shamt 0 with B=0x1234 -> t+1, result 0x1234.
- LUI B=0x0000ABCD -> 0xABCD0000. Op 1111 -> result 0, illegal_o=1, handshake still completes.
- Back-pressure: hold ready_i=0 for 10 cycles in RESP while toggling a_i, b_i and valid_i -> outputs unchanged and ready_o=0. After ready_i=1, valid_o drops and ready_o=1 the next cycle.
